// File: rtl/grey_pixel_if.sv
// Pixel/timing bus into and out of the grey pixel stage.
// The block drives the *_o side; its source drives the *_i side.
interface grey_pixel_if;
  logic        de_i;
  logic        hsync_i;
  logic        vsync_i;
  logic [23:0] rgb_i;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;
  logic [23:0] rgb_o;

  modport master (
    output de_i, hsync_i, vsync_i, rgb_i,
    input  de_o, hsync_o, vsync_o, rgb_o
  );

  modport slave (
    input  de_i, hsync_i, vsync_i, rgb_i,
    output de_o, hsync_o, vsync_o, rgb_o
  );
endinterface

// File: rtl/grey_pixel_proc.sv
// Pixel stage ahead of the TMDS encoder: colour pass-through or BT.601 grey.
// Mode toggles on a debounced button press and is applied only at a frame boundary.
module grey_pixel_proc #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          VSYNC_ACTIVE    = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       btn_n_i,
  grey_pixel_if.slave pix,
  output logic       grey_mode_o
);

  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned CH_W   = 8;
  localparam int unsigned PROD_W = 16;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PROD_W-1:0] K_R      = PROD_W'(77);
  localparam logic [PROD_W-1:0] K_G      = PROD_W'(150);
  localparam logic [PROD_W-1:0] K_B      = PROD_W'(29);
  localparam logic [PROD_W-1:0] ROUND_C  = PROD_W'(128);

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } timing_t;

  // Button synchroniser, debounce and mode control state
  logic             btn_meta_q, btn_sync_q;
  logic             btn_db_q, btn_db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             applied_q, applied_d;
  logic             vs_prev_q;

  // Pipeline state
  timing_t           tim1_q, tim2_q, tim3_q;
  logic [PIX_W-1:0]  rgb1_q, rgb2_q, rgb3_q, rgb3_d;
  logic              mode1_q, mode2_q;
  logic [PROD_W-1:0] pr_q, pg_q, pb_q;
  logic [PROD_W-1:0] pr_d, pg_d, pb_d, sum_c;
  logic [CH_W-1:0]   y_q, y_d;

  // A press is the accepted 1->0 change of the debounced level
  always_comb begin
    cnt_d     = cnt_q;
    btn_db_d  = btn_db_q;
    pending_d = pending_q;
    applied_d = applied_q;

    if (btn_sync_q == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      btn_db_d = btn_sync_q;
      if (!btn_sync_q) pending_d = ~pending_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Boundary samples the old pending value, so a same-cycle press waits a frame
    if ((pix.vsync_i == VSYNC_ACTIVE) && (vs_prev_q != VSYNC_ACTIVE)) begin
      applied_d = pending_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_db_q   <= 1'b1;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      applied_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
    end else begin
      btn_meta_q <= btn_n_i;
      btn_sync_q <= btn_meta_q;
      btn_db_q   <= btn_db_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      applied_q  <= applied_d;
      vs_prev_q  <= pix.vsync_i;
    end
  end

  always_comb begin
    pr_d   = PROD_W'(pix.rgb_i[23:16]) * K_R;
    pg_d   = PROD_W'(pix.rgb_i[15:8])  * K_G;
    pb_d   = PROD_W'(pix.rgb_i[7:0])   * K_B;
    sum_c  = pr_q + pg_q + pb_q + ROUND_C;
    y_d    = CH_W'(sum_c >> 8);
    rgb3_d = '0;
    if (tim2_q.de) begin
      rgb3_d = mode2_q ? {y_q, y_q, y_q} : rgb2_q;
    end
  end

  // Mode travels with each pixel so in-flight pixels keep the mode they entered with
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tim1_q  <= '0;
      tim2_q  <= '0;
      tim3_q  <= '0;
      rgb1_q  <= '0;
      rgb2_q  <= '0;
      rgb3_q  <= '0;
      mode1_q <= 1'b0;
      mode2_q <= 1'b0;
      pr_q    <= '0;
      pg_q    <= '0;
      pb_q    <= '0;
      y_q     <= '0;
    end else begin
      tim1_q  <= '{de: pix.de_i, hsync: pix.hsync_i, vsync: pix.vsync_i};
      rgb1_q  <= pix.rgb_i;
      mode1_q <= applied_q;
      pr_q    <= pr_d;
      pg_q    <= pg_d;
      pb_q    <= pb_d;
      tim2_q  <= tim1_q;
      rgb2_q  <= rgb1_q;
      mode2_q <= mode1_q;
      y_q     <= y_d;
      tim3_q  <= tim2_q;
      rgb3_q  <= rgb3_d;
    end
  end

  assign pix.de_o    = tim3_q.de;
  assign pix.hsync_o = tim3_q.hsync;
  assign pix.vsync_o = tim3_q.vsync;
  assign pix.rgb_o   = rgb3_q;
  assign grey_mode_o = applied_q;

endmodule

// File: tb/tb_grey_pixel_proc.sv
// Directed bench for grey_pixel_proc with a cycle-level reference model and output scoreboard.
module tb_grey_pixel_proc;

  logic clk = 1'b0;
  logic rst_n_i;
  logic btn_n_i;
  logic grey_mode_o;

  grey_pixel_if pif();

  grey_pixel_proc #(.DEBOUNCE_CYCLES(16), .VSYNC_ACTIVE(1'b1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .btn_n_i     (btn_n_i),
    .pix         (pif),
    .grey_mode_o (grey_mode_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int start;
  logic btn = 1'b1;
  logic [26:0] exp_q[$];
  logic [23:0] hist[int];

  // Reference model state
  logic m_s1, m_s2, m_db, m_pend, m_app, m_vsp;
  int   m_cnt;

  logic [23:0] tab_in  [6] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h6496C8, 24'h000000};
  logic [23:0] tab_out [6] = '{24'h4D4D4D, 24'h959595, 24'h1D1D1D, 24'hFFFFFF, 24'h8D8D8D, 24'h000000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] luma(input logic [23:0] p);
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]) + 128;
    return 8'(s >> 8);
  endfunction

  task automatic reset_model();
    m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b1; m_cnt = 0;
    m_pend = 1'b0; m_app = 1'b0; m_vsp = 1'b0;
    exp_q.delete();
    repeat (3) exp_q.push_back(27'd0);
  endtask

  // One clock cycle: drive, predict, then compare outputs at the falling edge
  task automatic cyc(input logic de, input logic hs, input logic vs, input logic [23:0] rgb);
    logic [23:0] px;
    logic [26:0] e;
    logic        exp_mode;
    pif.de_i = de; pif.hsync_i = hs; pif.vsync_i = vs; pif.rgb_i = rgb;
    btn_n_i = btn;
    px = !de ? 24'd0 : (m_app ? {3{luma(rgb)}} : rgb);
    exp_q.push_back({de, hs, vs, px});
    exp_mode = m_app;
    if (vs && !m_vsp) m_app = m_pend;
    m_vsp = vs;
    if (m_s2 == m_db) m_cnt = 0;
    else if (m_cnt == 15) begin
      m_cnt = 0; m_db = m_s2;
      if (!m_s2) m_pend = ~m_pend;
    end else m_cnt++;
    m_s2 = m_s1; m_s1 = btn;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("de_o",        32'(pif.de_o),    32'(e[26]));
    chk("hsync_o",     32'(pif.hsync_o), 32'(e[25]));
    chk("vsync_o",     32'(pif.vsync_o), 32'(e[24]));
    chk("rgb_o",       32'(pif.rgb_o),   32'(e[23:0]));
    chk("grey_mode_o", 32'(grey_mode_o), 32'(exp_mode));
    hist[cyc_n] = pif.rgb_o;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 24'd0);
  endtask

  task automatic vs_edge();
    cyc(1'b0, 1'b0, 1'b1, 24'd0);
    cyc(1'b0, 1'b0, 1'b1, 24'd0);
    idle(2);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_de"},   32'(pif.de_o),    32'd0);
    chk({tag, "_hs"},   32'(pif.hsync_o), 32'd0);
    chk({tag, "_vs"},   32'(pif.vsync_o), 32'd0);
    chk({tag, "_rgb"},  32'(pif.rgb_o),   32'd0);
    chk({tag, "_mode"}, 32'(grey_mode_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_i = 1'b1; btn_n_i = 1'b1;
    pif.de_i = 1'b0; pif.hsync_i = 1'b0; pif.vsync_i = 1'b0; pif.rgb_i = '0;
    #1 rst_n_i = 1'b0;
    #12;
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n_i = 1'b1;
    reset_model();

    // Colour pass-through with 3-cycle latency
    idle(3);
    start = cyc_n;
    cyc(1'b1, 1'b0, 1'b0, 24'h6496C8);
    idle(4);
    chk("pass_6496C8", 32'(hist[start + 3]), 32'h6496C8);

    // Press, mode stays until the vsync edge
    btn = 1'b0; idle(20);
    btn = 1'b1; idle(5);
    chk("mode_before_vs", 32'(grey_mode_o), 32'd0);
    vs_edge();
    chk("mode_after_vs", 32'(grey_mode_o), 32'd1);

    // Grey conversion table, back-to-back
    start = cyc_n;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, tab_in[i]);
    idle(4);
    for (int i = 0; i < 6; i++) chk("grey_tab", 32'(hist[start + 3 + i]), 32'(tab_out[i]));

    // Short pulses and bouncing must not toggle
    idle(20);
    repeat (3) begin
      btn = 1'b0; idle(5);
      btn = 1'b1; idle(8);
    end
    for (int i = 0; i < 12; i++) begin
      btn = (i % 2 == 1); idle(1);
    end
    btn = 1'b1; idle(20);
    vs_edge();
    chk("bounce_no_toggle", 32'(grey_mode_o), 32'd1);

    // Clean press toggles once, applied at the next edge
    btn = 1'b0; idle(20);
    btn = 1'b1; idle(3);
    chk("clean_press_pending", 32'(grey_mode_o), 32'd1);
    vs_edge();
    chk("clean_press_applied", 32'(grey_mode_o), 32'd0);
    idle(20);

    // Mid-frame press with active pixels
    vs_edge();
    for (int i = 0; i < 40; i++) begin
      btn = !(i >= 5 && i < 25);
      cyc(1'b1, 1'b0, 1'b0, 24'($urandom));
    end
    btn = 1'b1; idle(3);
    chk("midframe_old_mode", 32'(grey_mode_o), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 24'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1, 24'($urandom));
    idle(3);
    chk("midframe_new_mode", 32'(grey_mode_o), 32'd1);

    // DE low blanks the pixel
    start = cyc_n;
    cyc(1'b0, 1'b0, 1'b0, 24'hABCDEF);
    idle(4);
    chk("de0_blank", 32'(hist[start + 3]), 32'd0);

    // Random timing patterns in grey mode
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
    idle(3);

    // Asynchronous reset mid-frame in grey mode
    chk("mode_before_rst", 32'(grey_mode_o), 32'd1);
    repeat (4) cyc(1'b1, 1'b1, 1'b1, 24'h123456);
    #2 rst_n_i = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n_i = 1'b1;
    reset_model();
    chk("mode_after_rst", 32'(grey_mode_o), 32'd0);
    start = cyc_n;
    cyc(1'b1, 1'b0, 1'b0, 24'h6496C8);
    idle(4);
    chk("pass_after_rst", 32'(hist[start + 3]), 32'h6496C8);

    // Random timing patterns in colour mode
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
